// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - request/RAM bus bundle for memory_arbiter
// Signals:
//   iREN/iaddr -> ihit/iload                         instruction fetch side
//   dREN/dWEN/daddr/dstore -> dhit/dload             data side
//   ramREN/ramWEN/ramaddr/ramstore <- ramload/ram_ready   RAM side
//   mem_err                                          sticky watchdog abort flag
// Modports: slave = arbiter view, master = requester/RAM view.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  logic              mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter for instruction and data streams
// Ports:
//   CLK   in  clock, rising edge
//   nRST  in  asynchronous active-low reset
//   bus   memory_arbiter_if.slave (request inputs, hit/load outputs, RAM strobes, mem_err)
// Data requests win over instruction fetches, except that after MAX_DSTREAK
// consecutive data grants with a fetch waiting, the fetch is granted once.
// A watchdog aborts an access after TIMEOUT cycles without ram_ready.
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic            CLK,
  input logic            nRST,
  memory_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [SW-1:0]     streak;
  logic [WW-1:0]     wdog;
  logic              is_wr;
  logic              req_lost;

  logic              ihit_q;
  logic              dhit_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;
  logic              ramren_q;
  logic              ramwen_q;
  logic [ADDR_W-1:0] ramaddr_q;
  logic [DATA_W-1:0] ramstore_q;
  logic              mem_err_q;

  logic dreq;
  logic serv_req;
  logic data_first;
  logic acc_end;

  assign dreq = bus.dREN | bus.dWEN;

  // A waiting fetch only overrides data once the streak has saturated.
  assign data_first = dreq && !(bus.iREN && (streak == STREAK_MAX));

  // Request level of whichever side owns the current access.
  assign serv_req = (state == DACC) ? dreq : bus.iREN;

  // Access ends on RAM completion or when the watchdog runs out.
  assign acc_end = bus.ram_ready || (wdog == WDOG_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      streak     <= '0;
      wdog       <= '0;
      is_wr      <= 1'b0;
      req_lost   <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog     <= '0;
          req_lost <= 1'b0;
          if (data_first) begin
            state      <= DACC;
            is_wr      <= bus.dWEN;
            ramaddr_q  <= bus.daddr;
            ramstore_q <= bus.dWEN ? bus.dstore : '0;
            // Simultaneous dREN/dWEN is a write.
            ramren_q   <= ~bus.dWEN;
            ramwen_q   <= bus.dWEN;
            streak     <= bus.iREN ? (streak + SW'(1)) : '0;
          end else if (bus.iREN) begin
            state      <= IACC;
            is_wr      <= 1'b0;
            ramaddr_q  <= bus.iaddr;
            ramstore_q <= '0;
            ramren_q   <= 1'b1;
            ramwen_q   <= 1'b0;
            streak     <= '0;
          end
        end

        DACC, IACC: begin
          if (acc_end) begin
            state    <= DONE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            if (!bus.ram_ready) begin
              mem_err_q <= 1'b1;
            end
            // The hit is suppressed if the owner let go at any point in the access.
            if (state == DACC) begin
              if (!bus.ram_ready) begin
                dload_q <= '0;
              end else if (!is_wr) begin
                dload_q <= bus.ramload;
              end
              dhit_q <= dreq && !req_lost;
            end else begin
              iload_q <= bus.ram_ready ? bus.ramload : '0;
              ihit_q  <= bus.iREN && !req_lost;
            end
          end else begin
            wdog <= wdog + WW'(1);
            if (!serv_req) begin
              req_lost <= 1'b1;
            end
          end
        end

        DONE: begin
          ihit_q <= 1'b0;
          dhit_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ramren_q;
  assign bus.ramWEN   = ramwen_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.mem_err  = mem_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
module tb_memory_arbiter;
  localparam int MAXD = 4;
  localparam int TO   = 64;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  memory_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
    end
  endtask

  // RAM model
  logic [31:0] mem [0:255];
  int          ram_delay;
  int          ram_cnt;
  bit          ready_now;
  logic [31:0] ret_val;

  task automatic ram_respond();
    ready_now = 1'b0;
    if (bus.ramREN || bus.ramWEN) begin
      ram_cnt++;
      if (ram_delay != 0 && ram_cnt == ram_delay) begin
        bus.ram_ready = 1'b1;
        ready_now     = 1'b1;
        if (bus.ramWEN) begin
          mem[bus.ramaddr[9:2]] = bus.ramstore;
          bus.ramload = $urandom;
        end else begin
          bus.ramload = mem[bus.ramaddr[9:2]];
        end
        ret_val = bus.ramload;
      end else begin
        bus.ram_ready = 1'b0;
        bus.ramload   = $urandom;
      end
    end else begin
      ram_cnt       = 0;
      bus.ram_ready = 1'b0;
      bus.ramload   = $urandom;
    end
  endtask

  task automatic clear_inputs();
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.ram_ready = 1'b0;
    bus.ramload   = '0;
    ram_cnt       = 0;
  endtask

  task automatic tick();
    @(negedge CLK);
    ram_respond();
  endtask

  typedef struct {
    bit          is_i;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          exp_lat;
    bit          exp_ren;
    bit          exp_wen;
    logic [31:0] exp_load;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int lat = 0;
    bit got = 1'b0;
    bit hit_i = 1'b0;
    bit hit_d = 1'b0;
    ram_delay = v.delay;
    if (v.is_i) begin
      bus.iREN  = 1'b1;
      bus.iaddr = v.addr;
    end else begin
      bus.dREN   = v.rd;
      bus.dWEN   = v.wr;
      bus.daddr  = v.addr;
      bus.dstore = v.wdata;
    end
    while (!got && lat < 200) begin
      @(negedge CLK);
      lat++;
      if (bus.ihit || bus.dhit) begin
        got   = 1'b1;
        hit_i = bus.ihit;
        hit_d = bus.dhit;
      end else if (lat == 1) begin
        check({tag, " ramREN"}, 32'(bus.ramREN), 32'(v.exp_ren));
        check({tag, " ramWEN"}, 32'(bus.ramWEN), 32'(v.exp_wen));
        check({tag, " ramaddr"}, bus.ramaddr, v.addr);
        if (v.wr) check({tag, " ramstore"}, bus.ramstore, v.wdata);
      end else if (bus.ramREN || bus.ramWEN) begin
        check({tag, " ramaddr stable"}, bus.ramaddr, v.addr);
        if (v.wr) check({tag, " ramstore stable"}, bus.ramstore, v.wdata);
      end
      ram_respond();
    end
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " ihit"}, 32'(hit_i), 32'(v.is_i));
    check({tag, " dhit"}, 32'(hit_d), 32'(!v.is_i));
    check({tag, " load"}, v.is_i ? bus.iload : bus.dload, v.exp_load);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    tick();
  endtask

  // Runs n cycles, recording hit order; the held side keeps requesting after its hit.
  task automatic run_cycles(input int n, input bit hold_d, output string order, output int both);
    order = "";
    both  = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      if (bus.ihit && bus.dhit) both++;
      if (bus.ramREN && bus.ramWEN) both++;
      if (bus.dhit) begin
        order = {order, "D"};
        if (!hold_d) begin
          bus.dREN = 1'b0;
          bus.dWEN = 1'b0;
        end
      end
      if (bus.ihit) begin
        order = {order, "I"};
        bus.iREN = 1'b0;
      end
      ram_respond();
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  vec_t  vecs [8];
  string ord;
  int    both;

  // Random-phase model state
  bit          d_req, i_req, d_wr, in_acc, serv_d, exp_hit, want_d;
  logic [31:0] exp_ret, dload_m;
  int          streak, idle_wait, op;

  initial begin
    #500000;
    $display("FAIL global timeout reached");
    $fatal(1, "simulation time budget exhausted");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    ram_delay = 1;
    nRST = 1'b0;
    clear_inputs();
    #1;
    check("reset ihit", 32'(bus.ihit), 0);
    check("reset dhit", 32'(bus.dhit), 0);
    check("reset ramREN", 32'(bus.ramREN), 0);
    check("reset ramWEN", 32'(bus.ramWEN), 0);
    check("reset mem_err", 32'(bus.mem_err), 0);
    check("reset iload", bus.iload, 0);
    check("reset dload", bus.dload, 0);
    check("reset ramaddr", bus.ramaddr, 0);
    check("reset ramstore", bus.ramstore, 0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    //          is_i rd  wr  addr          wdata         dly lat ren wen load
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h040, 32'h0,         3,  4,  1'b1, 1'b0, 32'hA500_0010};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF,  2,  3,  1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h0,         1,  2,  1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h080, 32'h12345678,  4,  5,  1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h080, 32'h0,         1,  2,  1'b1, 1'b0, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h044, 32'h0,         2,  3,  1'b1, 1'b0, 32'hA500_0011};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h048, 32'h0,         0,  TO+1, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0,         2,  3,  1'b1, 1'b0, 32'hA500_00FF};

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 5) check("mem_err before timeout", 32'(bus.mem_err), 0);
      if (i >= 6) check($sformatf("mem_err sticky vec%0d", i), 32'(bus.mem_err), 1);
    end

    // Simultaneous data and instruction requests: data first.
    ram_delay = 2;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    run_cycles(20, 1'b0, ord, both);
    check_str("priority order", ord, "DI");
    check("priority overlap", 32'(both), 0);

    // Continuous writes with a waiting fetch: streak bound.
    ram_delay = 1;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hCAFEF00D;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    run_cycles(40, 1'b1, ord, both);
    check_str("streak order", ord.substr(0, 6), "DDDDIDD");
    check("streak overlap", 32'(both), 0);
    clear_inputs();
    for (int c = 0; c < 4; c++) tick();

    // Requester withdraws mid-access: result discarded.
    ram_delay = 3;
    bus.dREN = 1'b1; bus.daddr = 32'h44;
    tick();
    bus.dREN = 1'b0;
    run_cycles(8, 1'b0, ord, both);
    check_str("withdrawn no hit", ord, "");

    // Asynchronous reset in the middle of a data access.
    ram_delay = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h44;
    for (int c = 0; c < 3; c++) tick();
    check("pre-reset ramREN", 32'(bus.ramREN), 1);
    #2 nRST = 1'b0;
    #1;
    check("async reset ramREN", 32'(bus.ramREN), 0);
    check("async reset ramaddr", bus.ramaddr, 0);
    check("async reset mem_err", 32'(bus.mem_err), 0);
    check("async reset dload", bus.dload, 0);
    check("async reset iload", bus.iload, 0);
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    run_cycles(6, 1'b0, ord, both);
    check_str("no hit after reset", ord, "");
    check("idle strobes after reset", 32'(bus.ramREN | bus.ramWEN), 0);
    run_vec('{1'b1, 1'b1, 1'b0, 32'h040, 32'h0, 1, 2, 1'b1, 1'b0, 32'hA500_0010}, "post-reset");

    // Randomized traffic against a transaction-level model.
    do_reset();
    d_req = 0; i_req = 0; d_wr = 0; in_acc = 0; serv_d = 0; exp_hit = 0;
    exp_ret = '0; dload_m = '0; streak = 0; idle_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      check("rand one hit", 32'(bus.ihit & bus.dhit), 0);
      check("rand one strobe", 32'(bus.ramREN & bus.ramWEN), 0);
      if (exp_hit || bus.ihit || bus.dhit) begin
        check("rand hit timing", 32'(bus.ihit | bus.dhit), 32'(exp_hit));
        if (bus.ihit || bus.dhit) begin
          check("rand hit side", 32'(bus.dhit), 32'(serv_d));
          if (serv_d) begin
            if (!d_wr) dload_m = exp_ret;
            check("rand dload", bus.dload, dload_m);
            d_req = 1'b0;
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
          end else begin
            check("rand iload", bus.iload, exp_ret);
            i_req = 1'b0;
            bus.iREN = 1'b0;
          end
          in_acc = 1'b0;
        end
        exp_hit = 1'b0;
      end
      if ((bus.ramREN || bus.ramWEN) && !in_acc) begin
        want_d = d_req && !(i_req && streak == MAXD);
        check("rand grant addr", bus.ramaddr, want_d ? bus.daddr : bus.iaddr);
        check("rand grant wen", 32'(bus.ramWEN), 32'(want_d && d_wr));
        streak    = want_d ? (i_req ? streak + 1 : 0) : 0;
        serv_d    = want_d;
        in_acc    = 1'b1;
        ram_delay = int'($urandom_range(1, 4));
      end
      if (!in_acc && (d_req || i_req) && !(bus.ramREN || bus.ramWEN)) idle_wait++;
      else idle_wait = 0;
      check("rand liveness", 32'(idle_wait > 3), 0);
      if (idle_wait > 3) idle_wait = 0;
      ram_respond();
      if (ready_now) begin
        exp_hit = 1'b1;
        exp_ret = ret_val;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req      = 1'b1;
        op         = int'($urandom_range(0, 2));
        d_wr       = (op != 0);
        bus.dREN   = (op != 1);
        bus.dWEN   = (op != 0);
        bus.daddr  = 32'($urandom_range(0, 31)) << 2;
        bus.dstore = $urandom;
      end
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req     = 1'b1;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'($urandom_range(0, 31)) << 2;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
